// File: rtl/rgbmatrix_pixel_serializer.sv
// rgbmatrix_pixel_serializer
// Serialises 6-bit pixel-pair words into MSB-first bytes on `si`, adding the
// row-advance (bit7) and latch (bit6) flags for the downstream shift/latch
// stage. A free-running 3-bit phase counter, reset in lock-step with the
// downstream counter, frames the bytes; every eighth edge is a load slot.
// Optional build macro: RGBMATRIX_SERIALIZER_PATTERN_EN enables an internal
// colour-bar test pattern selected by pattern_sel.
module rgbmatrix_pixel_serializer #(
    parameter int COLS = 32,
    parameter int ROWS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic       pattern_sel,
    output logic       si,
    output logic [7:0] col,
    output logic [3:0] scan_row,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    logic [2:0] r_phase;
    logic [7:0] r_shreg;
    logic       r_si;
    logic [7:0] r_col;
    logic [3:0] r_row;
    logic       r_frame_done;
    logic       r_underrun;

    logic       w_pat;
    logic       w_load;
    logic       w_take;
    logic       w_last_col;
    logic       w_last_row;
    logic [5:0] w_data6;
    logic [7:0] w_byte;

`ifdef RGBMATRIX_SERIALIZER_PATTERN_EN
    assign w_pat = pattern_sel;
`else
    // Pattern generator is compiled out; the input is tied off here.
    assign w_pat = pattern_sel & 1'b0;
`endif

    // Phase 7 can only be reached after reset release, so this also covers
    // holding ready low while in reset.
    assign w_load     = (r_phase == 3'd7);
    assign pix_ready  = w_load && !w_pat;
    assign w_take     = w_load && (w_pat || pix_valid);
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);

    // Select the 6-bit payload: test pattern, upstream word, or black on underrun
    always_comb begin
        w_data6 = 6'd0;
        if (w_pat) begin
            w_data6 = {r_col[4:2], r_col[4:2]};
        end else if (pix_valid) begin
            w_data6 = pix_data;
        end
    end

    // Underrun slots carry no flags so the downstream stage neither advances nor latches
    assign w_byte = w_take ? {(r_col == 8'd0), w_last_col, w_data6} : 8'h00;

    // Phase counter plus load/shift of the serial byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 3'd0;
            r_shreg <= 8'h00;
            r_si    <= 1'b0;
        end else begin
            r_phase <= r_phase + 3'd1;
            if (w_load) begin
                r_si    <= w_byte[7];
                r_shreg <= {w_byte[6:0], 1'b0};
            end else begin
                r_si    <= r_shreg[7];
                r_shreg <= {r_shreg[6:0], 1'b0};
            end
        end
    end

    // Column/row scan counters advance only on accepted (or pattern) loads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= 8'd0;
            r_row <= 4'd0;
        end else if (w_take) begin
            if (w_last_col) begin
                r_col <= 8'd0;
                r_row <= w_last_row ? 4'd0 : r_row + 4'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    // Frame-done pulse and sticky underrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= w_take && w_last_col && w_last_row;
            if (w_load && !w_pat && !pix_valid) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign si         = r_si;
    assign col        = r_col;
    assign scan_row   = r_row;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule

// File: doc/rgbmatrix_pixel_serializer.md
Name: rgbmatrix_pixel_serializer

Overview:
- Upstream neighbour of the SPI-to-RGB-matrix shift/latch stage in the panel CPLD.
- Accepts 6-bit pixel-pair words (R1 G1 B1 R2 G2 B2) over a valid/ready handshake and emits them MSB-first on a single serial line `si`.
- Inserts the two control flags the downstream stage decodes:
  - bit7 = row-advance, set on the first column of each row.
  - bit6 = latch, set on the last column of each row.
- Runs on the same clock and reset as the downstream stage, so bit framing stays locked without any sync pattern.

Parameters:
- COLS, 32: pixel columns per panel row (2..256).
- ROWS, 16: scan rows per frame (2..16); sets frame_done spacing.

Ports:
- clk  input  1  shared system/shift clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pix_data  input  6  {R1,G1,B1,R2,G2,B2} for the current column.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  high when this block accepts a word at the next rising edge.
- pattern_sel  input  1  selects the internal test pattern; used only with the optional feature, otherwise ignored.
- si  output  1  serial data to the downstream stage.
- col  output  8  column index of the byte currently being shifted.
- scan_row  output  4  scan-row index of the byte currently being shifted.
- frame_done  output  1  one-cycle pulse after the last byte of row ROWS-1 is loaded.
- underrun  output  1  sticky: a load slot found no valid data.

Behaviour:
- Reset (async, reset==0) values:
  - si=0, phase=0, shreg=0x00, col=0, scan_row=0, frame_done=0, underrun=0.
  - pix_ready=0 while in reset.
- Phase counter:
  - 3-bit, +1 every rising edge, wraps 7->0.
  - Matches the downstream 3-bit counter exactly, because both leave reset on the same edge.
- Byte slots and si timing:
  - Byte n occupies the si samples taken at edges 8n+1..8n+8.
  - Byte 0 is the reset pad, 0x00: its bit7 is the reset value of si; bits 6..0 are driven 0.
- Load edge (pre-edge phase==7):
  - Form byte = {col==0, col==COLS-1, data6}.
  - Drive si <= byte[7]; shreg <= {byte[6:0], 0}.
- Other edges: si <= shreg[7]; shreg <= shreg<<1.
- Handshake:
  - pix_ready = (phase==7) && reset_released; combinational from registers only.
  - A transfer occurs on the edge where pix_valid && pix_ready; at most one word per 8 clocks.
  - pix_data must be stable only in the ready cycle.
- Underrun (pix_ready=1, pix_valid=0):
  - Load 0x00 (no flags, black).
  - col and scan_row do NOT advance.
  - underrun<=1 and stays set until reset.
- Column/row advance on each accepted word:
  - col wraps COLS-1 -> 0; on that wrap scan_row increments.
  - scan_row wraps ROWS-1 -> 0.
  - frame_done=1 in the cycle after loading the col=COLS-1, scan_row=ROWS-1 word; 0 otherwise.
- Widths:
  - col is 8 bits and compares against COLS-1 in 8 bits.
  - scan_row is 4 bits; ROWS=16 wraps naturally.
- Reset mid-byte: all state returns to reset values immediately. The next byte after release is again the 0x00 pad.
- No other states. The datapath is a phase-driven load/shift loop with a row/column scan counter pair.

Optional Feature:
- Macro: RGBMATRIX_SERIALIZER_PATTERN_EN.
- With the macro, while pattern_sel==1:
  - Load data6 = {col[4:2], col[4:2]} (8-column colour bars, top and bottom identical).
  - pix_ready is held 0 and pix_data/pix_valid are ignored.
  - No underrun is flagged; col/scan_row advance every load slot.
- Without the macro: pattern_sel has no effect, and behaviour is exactly as in Behaviour.

Test Plan:
1. Reset release, pix_valid=0 for 24 clocks -> si=0 throughout; pix_ready pulses at clocks 8,16,24; underrun=1 after clock 8; col stays 0.
2. COLS=32, ROWS=16, continuous valid, pix_data=0x2A -> bytes on si: 0x00 pad, then 0xAA (col 0), then 0x2A x30, then 0x6A (col 31); downstream-model row 15->0, one latch pulse per row.
3. Stream 512 words -> frame_done pulses exactly once, one cycle after the 512th load; scan_row returns to 0; col=0.
4. Drop pix_valid for one slot at col 5 -> 0x00 emitted in that slot; next accepted word still carries col=5; underrun stays 1 until reset.
5. Assert reset at phase 3 mid-byte -> si=0 and col/scan_row=0 immediately; after release the first byte is the 0x00 pad and alignment is correct (second byte reaches downstream rgbs intact).
6. With RGBMATRIX_SERIALIZER_PATTERN_EN and pattern_sel=1 -> col 0 byte 0x80, col 4 byte 0x09, col 31 byte 0x7F; pix_ready stays 0.
